// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and the default bit
// period, used by both the receiver and the transmitter so they stay consistent.
package uart_pkg;

    localparam int DATA_BITS         = 8;
    localparam int UART_CLKS_PER_BIT = 5000;  // 100 MHz / 5000 = 20 kbaud

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo_if.sv
// Byte-wide valid/ready handshake feeding the transmitter; a transfer occurs on
// a rising clock edge with din_vld and din_rdy both high.
interface uart_tx_fifo_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] din;
    logic                 din_vld;
    logic                 din_rdy;

    modport master (output din, output din_vld, input  din_rdy);
    modport slave  (input  din, input  din_vld, output din_rdy);

endinterface : uart_tx_fifo_if

// File: rtl/uart_byte_fifo.sv
// Small synchronous FIFO with registered pointers and occupancy count.
// rd_data shows the head entry combinationally so a pop can load it the same edge.
module uart_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: non-blocking assignments for every register so all state updates
    // see the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides what is
    // valid, and leaving the array reset-free lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule : uart_byte_fifo

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out LSB
// first between a start and a stop bit, back-to-back while the FIFO has data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          res,
    uart_tx_fifo_if.slave host,
    output logic          TX,
    output logic          busy
);
    localparam int                 BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e          state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_end;
    logic                 pop;

    uart_byte_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .res     (res),
        .wr_en   (host.din_vld),
        .wr_data (host.din),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign host.din_rdy = !fifo_full;
    assign bit_end      = (baud_cnt == BAUD_LAST);

    // Pops happen from IDLE, or at the end of a stop bit so frames run without a gap.
    assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            TX        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg <= fifo_rd_data;
                        TX        <= 1'b0;
                        state     <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        TX       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            TX    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // TX takes the next bit now, since the register is the pin.
                            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                            TX        <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= fifo_rd_data;
                            TX        <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                end
            endcase
        end
    end

endmodule : uart_tx_fifo

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO and serialises them onto the TX line as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). It is the transmit half of the UART_top datapath, the counterpart of the existing receiver. It drives the TX pin at the same bit period the receiver samples: 5000 clocks per bit at 100 MHz.

## Interface
- CLKS_PER_BIT, 5000, clock cycles per serial bit; legal range 2 to 65535.
- FIFO_DEPTH, 4, byte entries in the input FIFO; power of two, minimum 2.
- clk  input  1  system clock; all logic on the rising edge.
- res  input  1  synchronous, active-high reset.
- din  input  8  byte to transmit.
- din_vld  input  1  din is valid.
- din_rdy  output  1  FIFO can accept a byte; a transfer occurs on a rising edge with din_vld and din_rdy both high.
- TX  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.

## Operation
- Reset values after an edge with res=1:
  - TX=1, busy=0, din_rdy=1.
  - FIFO empty, FSM in IDLE, bit counter 0, baud counter 0.
- Reset has priority over all other activity. Reset mid-frame:
  - the in-flight byte and all FIFO contents are discarded;
  - TX returns high at the reset edge, with no truncated stop bit.
- FIFO:
  - din_rdy = !full, derived from the registered count.
  - A push while full is ignored. din_rdy stays low in that cycle even if a pop occurs on the same edge.
  - A push and a pop on the same edge leave the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: TX=1. When the FIFO is non-empty, pop the head into the shift register, drive TX=0 and go to START.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. At the end:
    - if the FIFO is non-empty, pop, drive TX=0 and go to START directly, with no idle gap;
    - otherwise go to IDLE.
- Baud counter:
  - width is clog2(CLKS_PER_BIT);
  - counts 0 to CLKS_PER_BIT-1, then resets to 0 and flags the bit end;
  - held at 0 in IDLE.
- Bit index is 3 bits wide and counts 0 to 7.
- busy = (state != IDLE) || !empty.
- TX is driven straight from a register, with no combinational path to the pin.

## Timing
- Byte accepted at edge k into an empty FIFO while IDLE:
  - FIFO non-empty after edge k;
  - pop occurs and TX falls at edge k+1;
  - busy rises after edge k.
- Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- One frame lasts 10·CLKS_PER_BIT cycles.
- Back-to-back frames: the start bit of frame n+1 begins on the edge immediately after the last stop-bit cycle of frame n.
- The FIFO slot is freed at the pop edge. din_rdy can rise one cycle after the pop.
- busy falls on the edge that ends the last stop bit when the FIFO is empty.
- Throughput is at most one byte per 10·CLKS_PER_BIT cycles. Up to FIFO_DEPTH+1 bytes can be outstanding: FIFO_DEPTH in the FIFO plus one in the shift register.

## Structure
- Shared package uart_pkg holds:
  - FSM state encoding: IDLE, START, DATA, STOP;
  - DATA_BITS=8;
  - default CLKS_PER_BIT=5000, so the receiver and transmitter stay consistent.
- Sub-module uart_byte_fifo:
  - parameters: WIDTH=8, DEPTH;
  - ports: clk, res, wr_en, wr_data, rd_en, rd_data, full, empty;
  - registered count and pointers;
  - rd_data is combinational from the head entry.
- Top level uart_tx_fifo contains the FIFO instance, the FSM, the baud counter, the shift register and the TX register.

## Test plan
- Single byte, CLKS_PER_BIT=16:
  - push 8'h09 while idle;
  - TX falls one cycle after acceptance;
  - line reads 0,1,0,0,1,0,0,0,0,1 with each level held 16 cycles;
  - busy stays high 160 cycles, then TX stays at 1.
- Back-to-back at CLKS_PER_BIT=5000: push 8'h09, 8'h06, 8'h0a consecutively.
  - Three contiguous frames, 150000 cycles in total.
  - No idle cycle between a stop bit and the next start bit.
  - Looping TX into the existing receiver returns 09, 06, 0a.
- FIFO full, DEPTH=4, CLKS_PER_BIT=16:
  - hold din_vld high with bytes 01..08;
  - exactly 5 bytes are accepted before din_rdy goes low;
  - din_rdy rises after each pop;
  - all 8 bytes are transmitted in order with no loss or duplication.
- Simultaneous push and pop: push timed to the end-of-stop pop edge with the FIFO holding 1 entry.
  - The count stays at 1.
  - The byte order is preserved.
- Reset mid-frame:
  - assert res for 1 cycle during data bit 3 of 8'hA5, with 2 bytes queued;
  - TX=1, busy=0 and din_rdy=1 at the next edge;
  - no further frames are sent.
  - A new byte 8'h3C pushed afterwards is transmitted correctly.
